apb_uart_master: RTL and testbench
==================================

Name: apb_uart_master

Overview:
APB initiator that drives the UART register interface (PSEL/PENABLE/PADDR/PWRITE/PWDATA, PRDATA back) from a simple command/response handshake. Used by the on-chip controller and the FPGA test harness to program the UART and to stream bytes in and out of it. Each command becomes one APB transfer (SETUP then ACCESS), with PREADY wait-state support and a timeout. One transfer is outstanding at a time.

Parameters:
ADDR_W, 2, APB address width (matches the UART PADDR).
DATA_W, 8, APB data width (matches PWDATA/PRDATA).
TIMEOUT, 16, maximum ACCESS-phase wait cycles before the transfer is aborted with error; legal range 1..255.

Ports:
PCLK  input  1  single clock; all logic on rising edge.
PRESET  input  1  asynchronous, active-high reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  block accepts a command (IDLE only).
cmd_write  input  1  1 = APB write, 0 = APB read.
cmd_addr  input  ADDR_W  register address.
cmd_wdata  input  DATA_W  write data.
rsp_valid  output  1  response present.
rsp_ready  input  1  consumer accepts the response.
rsp_rdata  output  DATA_W  read data (0 for writes and on error).
rsp_err  output  1  transfer timed out.
busy  output  1  high in any state other than IDLE.
PSEL  output  1  APB select.
PENABLE  output  1  APB enable.
PWRITE  output  1  APB direction.
PADDR  output  ADDR_W  APB address.
PWDATA  output  DATA_W  APB write data.
PRDATA  input  DATA_W  APB read data.
PREADY  input  1  APB ready; tie high for zero-wait slaves.

Behaviour:
- Reset (async, PRESET=1): state IDLE; PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, busy = 0; PADDR, PWDATA, rsp_rdata = 0; wait counter = 0. Outputs are registered, except that cmd_ready is decoded from state.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready=1. When cmd_valid=1 on an edge: latch cmd_write/cmd_addr/cmd_wdata into PWRITE/PADDR/PWDATA and go to SETUP. PWDATA is loaded on reads as well.
- SETUP (exactly 1 cycle): PSEL=1, PENABLE=0. Always go to ACCESS.
- ACCESS: PSEL=1, PENABLE=1. PADDR, PWRITE and PWDATA are stable from SETUP through the end of ACCESS.
  - PREADY=1 on an edge: for reads, rsp_rdata<=PRDATA; for writes, rsp_rdata<=0. Then rsp_err<=0, rsp_valid<=1, PSEL<=0, PENABLE<=0, and go to RESP.
  - PREADY=0: wait counter increments. When the counter equals TIMEOUT with PREADY still low, abort: rsp_err<=1, rsp_rdata<=0, rsp_valid<=1, PSEL/PENABLE<=0, go to RESP.
  - PREADY=1 on the same edge the counter reaches TIMEOUT: the transfer completes normally and no error is flagged.
- RESP: rsp_valid=1, and rsp_rdata/rsp_err are held until rsp_valid&rsp_ready on an edge. Then rsp_valid<=0, the counter clears, and the FSM goes to IDLE. cmd_valid is ignored in RESP.
- Throughput: with PREADY=1 and rsp_ready=1, a transfer takes 4 cycles from command acceptance to the next cmd_ready (IDLE, SETUP, ACCESS, RESP).
- After a transfer, PADDR/PWDATA/PWRITE hold their last values. PSEL=0 in IDLE and RESP.
- Wait counter: width is ceil(log2(TIMEOUT+1)) bits. It cannot wrap because it saturates at TIMEOUT.
- Reset asserted mid-transfer: PSEL/PENABLE drop immediately (async). The response is lost and no rsp_valid is produced.
- A change in cmd_* while not in IDLE has no effect.

Test Plan:
- Write, zero wait: cmd write addr=2'b01 data=8'hA5, PREADY=1 -> SETUP cycle PSEL=1/PENABLE=0, then ACCESS PENABLE=1 with PADDR=1, PWDATA=A5, PWRITE=1; next cycle rsp_valid=1, rsp_err=0, rsp_rdata=0.
- Read with 3 wait states: cmd read addr=0, PREADY low for 3 ACCESS cycles then high, PRDATA=8'h3C -> PENABLE high for 4 cycles, rsp_rdata=3C, rsp_err=0.
- Timeout: TIMEOUT=16, PREADY held 0 -> abort after 16 wait cycles, PSEL/PENABLE=0, rsp_valid=1, rsp_err=1, rsp_rdata=0. Repeat with PREADY=1 on cycle 16 -> rsp_err=0.
- Response backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stay stable, cmd_ready=0, a new cmd_valid is not accepted; rsp_ready=1 -> IDLE next cycle.
- Back-to-back: 4 writes with cmd_valid and rsp_ready held high -> one accepted every 4 cycles, 4 distinct APB transfers, PSEL low between them.
- Reset mid-ACCESS: assert PRESET asynchronously while PENABLE=1 -> PSEL/PENABLE/busy=0 before the next edge, no rsp_valid, and a subsequent command completes normally.

Source files
------------

// File: rtl/apb_uart_master.sv
// apb_uart_master: command/response handshake to single-outstanding APB initiator
// for the UART register file, with PREADY wait states and an ACCESS-phase timeout.
`timescale 1ns/1ps
`default_nettype none

module apb_uart_master #(
  parameter int ADDR_W  = 2,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  // command side
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  // response side
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  // APB initiator
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // The TIMEOUT-th low-PREADY edge aborts, so the last legal count before abort is TIMEOUT-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] wait_cnt;
  logic             wait_last;

  assign cmd_ready = (state == S_IDLE);
  assign wait_last = (wait_cnt == CNT_LAST);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (cmd_valid) state_nx = S_SETUP;
      S_SETUP:  state_nx = S_ACCESS;
      S_ACCESS: if (PREADY || wait_last) state_nx = S_RESP;
      S_RESP:   if (rsp_ready) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      busy <= (state_nx != S_IDLE);
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            PWRITE <= cmd_write;
            PADDR  <= cmd_addr;
            PWDATA <= cmd_wdata;
            PSEL   <= 1'b1;
          end
        end
        S_SETUP: begin
          PENABLE <= 1'b1;
        end
        S_ACCESS: begin
          // A ready slave wins over the timeout on the same edge.
          if (PREADY) begin
            rsp_rdata <= PWRITE ? '0 : PRDATA;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
          end else begin
            if (wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + CNT_W'(1);
            if (wait_last) begin
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              rsp_valid <= 1'b1;
              PSEL      <= 1'b0;
              PENABLE   <= 1'b0;
            end
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            wait_cnt  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_apb_uart_master.sv
// tb_apb_uart_master: table vectors, random transfers vs. a transfer-level model,
// and hand sequences for back-to-back throughput and asynchronous reset.
`timescale 1ns/1ps
`default_nettype none

module tb_apb_uart_master;

  localparam int TIMEOUT = 16;

  logic       PCLK, PRESET;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [1:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid, rsp_ready, rsp_err, busy;
  logic [7:0] rsp_rdata;
  logic       PSEL, PENABLE, PWRITE, PREADY;
  logic [1:0] PADDR;
  logic [7:0] PWDATA, PRDATA;

  apb_uart_master #(.ADDR_W(2), .DATA_W(8), .TIMEOUT(TIMEOUT)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One complete transfer: slave holds PREADY low for `waits` ACCESS cycles,
  // consumer holds rsp_ready low for `bp` cycles of RESP.
  task automatic do_xfer(input bit wr, input logic [1:0] a, input logic [7:0] wd,
                         input int waits, input logic [7:0] pd, input int bp,
                         input logic [7:0] e_rd, input bit e_err, input int e_acc);
    int         acc;
    logic [7:0] hold_rd;
    logic       hold_err;
    chk("idle_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd; PREADY = 1'b0;
    @(posedge PCLK); #1;
    cmd_valid = 1'($urandom_range(0, 1)); cmd_write = ~wr; cmd_addr = a + 2'd1; cmd_wdata = ~wd;
    chk("setup_psel_penable", {PSEL, PENABLE}, 2'b10);
    chk("setup_busy_cmd_ready", {busy, cmd_ready}, 2'b10);
    @(posedge PCLK); #1;
    acc = 0;
    while (PENABLE && acc <= TIMEOUT + 2) begin
      acc++;
      chk("access_attrs", {PSEL, PWRITE, PADDR, PWDATA}, {1'b1, wr, a, wd});
      PREADY = (acc > waits);
      PRDATA = PREADY ? pd : 8'($urandom);
      @(posedge PCLK); #1;
    end
    PREADY = 1'b0; PRDATA = 8'($urandom);
    chk("access_cycles", acc, e_acc);
    chk("resp_valid", rsp_valid, 1);
    chk("resp_psel_penable", {PSEL, PENABLE}, 2'b00);
    chk("resp_rdata", rsp_rdata, e_rd);
    chk("resp_err", rsp_err, e_err);
    hold_rd = rsp_rdata; hold_err = rsp_err;
    for (int i = 0; i < bp; i++) begin
      cmd_valid = 1'b1;
      @(posedge PCLK); #1;
      chk("bp_hold", {rsp_valid, cmd_ready, rsp_err, rsp_rdata}, {1'b1, 1'b0, hold_err, hold_rd});
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge PCLK); #1;
    rsp_ready = 1'b0;
    chk("resp_done", {rsp_valid, cmd_ready, busy, PSEL}, 4'b0100);
  endtask

  typedef struct {
    bit         wr;
    logic [1:0] addr;
    logic [7:0] wdata;
    int         waits;
    logic [7:0] prdata;
    int         bp;
    logic [7:0] exp_rdata;
    bit         exp_err;
    int         exp_acc;
  } vec_t;

  vec_t       tbl[6];
  bit         r_wr, r_err;
  logic [1:0] r_addr;
  logic [7:0] r_wd, r_pd, r_rd;
  int         r_waits, r_bp, r_acc;
  int         acc_cyc[4];
  logic [1:0] bb_addr[4];
  logic [7:0] bb_data[4];
  int         nacc, nen, nsel, nrsp;

  initial begin
    tbl[0] = '{1'b1, 2'd1, 8'hA5, 0,  8'h77, 0, 8'h00, 1'b0, 1};
    tbl[1] = '{1'b0, 2'd0, 8'h11, 3,  8'h3C, 0, 8'h3C, 1'b0, 4};
    tbl[2] = '{1'b0, 2'd2, 8'h22, 16, 8'h5A, 0, 8'h00, 1'b1, 16};
    tbl[3] = '{1'b0, 2'd3, 8'h33, 15, 8'hC3, 0, 8'hC3, 1'b0, 16};
    tbl[4] = '{1'b1, 2'd2, 8'h5A, 20, 8'h99, 1, 8'h00, 1'b1, 16};
    tbl[5] = '{1'b0, 2'd1, 8'h44, 0,  8'h81, 5, 8'h81, 1'b0, 1};

    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; PREADY = 1'b0; PRDATA = '0;
    repeat (2) @(posedge PCLK);
    #1;
    chk("reset_apb", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, '0);
    chk("reset_rsp", {rsp_valid, rsp_err, busy, rsp_rdata}, '0);
    chk("reset_cmd_ready", cmd_ready, 1);
    @(negedge PCLK); PRESET = 1'b0;
    @(posedge PCLK); #1;

    foreach (tbl[i])
      do_xfer(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].waits, tbl[i].prdata,
              tbl[i].bp, tbl[i].exp_rdata, tbl[i].exp_err, tbl[i].exp_acc);

    // Random transfers against a transfer-level model.
    for (int n = 0; n < 24; n++) begin
      r_wr    = 1'($urandom_range(0, 1));
      r_addr  = 2'($urandom);
      r_wd    = 8'($urandom);
      r_pd    = 8'($urandom);
      r_waits = $urandom_range(0, TIMEOUT + 4);
      r_bp    = $urandom_range(0, 3);
      r_err   = (r_waits >= TIMEOUT);
      r_rd    = (r_wr || r_err) ? 8'h00 : r_pd;
      r_acc   = r_err ? TIMEOUT : r_waits + 1;
      do_xfer(r_wr, r_addr, r_wd, r_waits, r_pd, r_bp, r_rd, r_err, r_acc);
    end

    // Back-to-back writes with zero-wait slave and always-ready consumer.
    for (int i = 0; i < 4; i++) begin
      bb_addr[i] = 2'(3 - i);
      bb_data[i] = 8'hC0 + 8'(i * 5);
    end
    nacc = 0; nen = 0; nsel = 0; nrsp = 0;
    PREADY = 1'b1; rsp_ready = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1;
    for (int c = 0; c < 24; c++) begin
      if (PENABLE && nen < 4) begin
        chk("b2b_attrs", {PWRITE, PADDR, PWDATA}, {1'b1, bb_addr[nen], bb_data[nen]});
        nen++;
      end
      if (PSEL) nsel++;
      if (rsp_valid) begin
        chk("b2b_rsp", {rsp_err, rsp_rdata}, 9'h000);
        nrsp++;
      end
      if (cmd_ready && nacc < 4) begin
        acc_cyc[nacc] = c;
        cmd_addr = bb_addr[nacc]; cmd_wdata = bb_data[nacc];
        nacc++;
      end else if (cmd_ready) begin
        cmd_valid = 1'b0;
      end
      @(posedge PCLK); #1;
    end
    cmd_valid = 1'b0; rsp_ready = 1'b0; PREADY = 1'b0;
    chk("b2b_accepts", nacc, 4);
    chk("b2b_transfers", nen, 4);
    chk("b2b_psel_cycles", nsel, 8);
    chk("b2b_responses", nrsp, 4);
    for (int i = 1; i < 4; i++) chk("b2b_interval", acc_cyc[i] - acc_cyc[i-1], 4);

    // Asynchronous reset in the middle of ACCESS.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 2'd2; PREADY = 1'b0;
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    chk("pre_reset_penable", {PSEL, PENABLE}, 2'b11);
    #2 PRESET = 1'b1;
    #1;
    chk("async_reset_drop", {PSEL, PENABLE, busy, rsp_valid}, 4'b0000);
    @(negedge PCLK); PRESET = 1'b0;
    PREADY = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge PCLK); #1;
      chk("post_reset_quiet", {rsp_valid, cmd_ready, PSEL}, 3'b010);
    end
    PREADY = 1'b0; rsp_ready = 1'b0;
    do_xfer(1'b0, 2'd3, 8'h5E, 2, 8'hE7, 1, 8'hE7, 1'b0, 3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
